// File: rtl/string_pkg.sv
// rtl/string_pkg.sv - shared constants and FSM state type for the string sender (STRING_SENDER_EOL_EN adds the EOL state)
package string_pkg;

    localparam int DEF_CW     = 7;
    localparam int DEF_NCHARS = 11;

    localparam logic [6:0] CH_NULL   = 7'b0000000;
    localparam logic [6:0] CH_ENTER  = 7'b0010000;
    localparam logic [6:0] CH_DELETE = 7'b0001000;
    localparam logic [6:0] CH_TILDE  = 7'b0111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SEND,
        ST_GAP,
        ST_FIN
`ifdef STRING_SENDER_EOL_EN
        , ST_EOL
`endif
    } state_t;

endpackage

// File: rtl/string_sender.sv
// rtl/string_sender.sv - snapshots a packed string and streams its non-empty characters (STRING_SENDER_EOL_EN appends an enter code)
module string_sender
    import string_pkg::*;
#(
    parameter int NCHARS = DEF_NCHARS,
    parameter int CW     = DEF_CW,
    parameter int GAP    = 4
) (
    input  logic               clk,
    input  logic               btn1,
    input  logic               complete,
    input  logic [NCHARS*CW-1:0] str,
    output logic [CW-1:0]      out_char,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    localparam int IW = $clog2(NCHARS + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHARS - 1);
`ifdef STRING_SENDER_EOL_EN
    // idx parks one past the last slot while the terminator is in flight
    localparam logic [IW-1:0] EOL_IDX = IW'(NCHARS);
`endif

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [GW-1:0]          gcnt, gcnt_n;
    logic [NCHARS*CW-1:0]   shadow, shadow_n;
    logic [CW-1:0]          out_char_n;
    logic                   out_valid_n;
    logic                   done_n;
    logic                   overrun_n;
    logic [CW-1:0]          slot;
    logic                   adv;

    always_comb begin
        slot = '0;
        for (int k = 0; k < NCHARS; k++) begin
            if (idx == IW'(k)) begin
                slot = shadow[k*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk or negedge btn1) begin
        if (!btn1) begin
            state     <= ST_IDLE;
            idx       <= '0;
            gcnt      <= '0;
            shadow    <= '0;
            out_char  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            gcnt      <= gcnt_n;
            shadow    <= shadow_n;
            out_char  <= out_char_n;
            out_valid <= out_valid_n;
            busy      <= (state_n != ST_IDLE);
            done      <= done_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        gcnt_n      = gcnt;
        shadow_n    = shadow;
        out_char_n  = out_char;
        out_valid_n = out_valid;
        done_n      = 1'b0;
        overrun_n   = complete && (state != ST_IDLE);
        adv         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (complete) begin
                    shadow_n = str;
                    idx_n    = '0;
                    state_n  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (slot != '0) begin
                    out_char_n  = slot;
                    out_valid_n = 1'b1;
                    state_n     = ST_SEND;
                end else if (idx == LAST) begin
`ifdef STRING_SENDER_EOL_EN
                    state_n = ST_EOL;
`else
                    state_n = ST_FIN;
`endif
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            ST_SEND: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    if (GAP > 0) begin
                        gcnt_n  = GW'(GAP);
                        state_n = ST_GAP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt == '0) begin
                    adv = 1'b1;
                end else begin
                    gcnt_n = gcnt - GW'(1);
                end
            end
            ST_FIN: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
`ifdef STRING_SENDER_EOL_EN
            ST_EOL: begin
                out_char_n  = CW'(CH_ENTER);
                out_valid_n = 1'b1;
                idx_n       = EOL_IDX;
                state_n     = ST_SEND;
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (adv) begin
`ifdef STRING_SENDER_EOL_EN
            if (idx == EOL_IDX) begin
                state_n = ST_FIN;
            end else if (idx == LAST) begin
                state_n = ST_EOL;
            end else begin
                idx_n   = idx + IW'(1);
                state_n = ST_SCAN;
            end
`else
            if (idx == LAST) begin
                state_n = ST_FIN;
            end else begin
                idx_n   = idx + IW'(1);
                state_n = ST_SCAN;
            end
`endif
        end
    end

endmodule

// File: tb/tb_string_sender.sv
// tb/tb_string_sender.sv - self-checking bench for string_sender (expectations follow STRING_SENDER_EOL_EN)
module tb_string_sender;

    localparam int NCH = 11;
    localparam int W   = 7;
`ifdef STRING_SENDER_EOL_EN
    localparam int EOL_LAT = 7;
    localparam int EOL_N   = 1;
`else
    localparam int EOL_LAT = 0;
    localparam int EOL_N   = 0;
`endif

    logic             clk = 1'b0;
    logic             btn1;
    logic             complete;
    logic [NCH*W-1:0] str;
    logic [W-1:0]     out_char;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             overrun;

    string_sender #(.NCHARS(NCH), .CW(W), .GAP(4)) dut (
        .clk(clk), .btn1(btn1), .complete(complete), .str(str),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*W-1:0] s;
        int               n;
        logic [W-1:0]     c [4];
        int               lat;
    } vec_t;

    vec_t vecs [5];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    logic pv = 1'b0;
    logic [W-1:0] got [$];
    int rise_cyc [$];
    int hs_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // handshakes are observed mid-cycle; inputs only move just after posedge
    always @(negedge clk) begin
        if (btn1) begin
            if (out_valid && out_ready) begin
                got.push_back(out_char);
                hs_cyc.push_back(cyc + 1);
            end
            if (out_valid && !pv) rise_cyc.push_back(cyc);
            if (done) done_cnt++;
            if (overrun) ovr_cnt++;
        end
        pv = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (done) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int v);
        int lat;
        int d0;
        int a;
        logic [W-1:0] e [$];
        e = {};
        for (int i = 0; i < vecs[v].n; i++) e.push_back(vecs[v].c[i]);
`ifdef STRING_SENDER_EOL_EN
        e.push_back(7'b0010000);
`endif
        got.delete();
        d0 = done_cnt;
        str = vecs[v].s;
        complete = 1'b1;
        tick();
        complete = 1'b0;
        wait_done(lat);
        chk($sformatf("v%0d_done_latency", v), lat, vecs[v].lat + EOL_LAT);
        tick();
        chk($sformatf("v%0d_count", v), got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            a = (i < got.size()) ? int'(got[i]) : -1;
            chk($sformatf("v%0d_char%0d", v, i), a, int'(e[i]));
        end
        chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
        chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
    endtask

    initial begin
        int lat;
        int bad;
        int d0;
        int o0;
        logic [NCH*W-1:0] full_s;

        full_s = {56'b0, 7'b0111011, 7'b0000111, 7'b1111011};
        vecs[0].s = full_s;
        vecs[0].n = 3; vecs[0].c = '{7'b1111011, 7'b0000111, 7'b0111011, 7'b0}; vecs[0].lat = 30;
        vecs[1].s = {35'b0, 7'b1000110, 35'b0};
        vecs[1].n = 1; vecs[1].c = '{7'b1000110, 7'b0, 7'b0, 7'b0}; vecs[1].lat = 18;
        vecs[2].s = '0;
        vecs[2].n = 0; vecs[2].c = '{7'b0, 7'b0, 7'b0, 7'b0}; vecs[2].lat = 12;
        vecs[3].s = {70'b0, 7'b1111011};
        vecs[3].n = 1; vecs[3].c = '{7'b1111011, 7'b0, 7'b0, 7'b0}; vecs[3].lat = 18;
        vecs[4].s = {7'b0111111, 70'b0};
        vecs[4].n = 1; vecs[4].c = '{7'b0111111, 7'b0, 7'b0, 7'b0}; vecs[4].lat = 18;

        btn1 = 1'b0; complete = 1'b0; str = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_char", int'(out_char), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        btn1 = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) run_vec(v);

        // first-character latency and inter-character spacing
        got.delete(); rise_cyc.delete(); hs_cyc.delete();
        d0 = done_cnt;
        str = full_s;
        complete = 1'b1;
        tick();
        complete = 1'b0;
        chk("lat_edge1_valid", int'(out_valid), 0);
        tick();
        chk("lat_edge2_valid", int'(out_valid), 1);
        chk("lat_edge2_char", int'(out_char), 7'b1111011);
        wait_done(lat);
        tick();
        chk("spacing_count", (rise_cyc.size() >= 3 && hs_cyc.size() >= 2) ? 1 : 0, 1);
        if (rise_cyc.size() >= 3 && hs_cyc.size() >= 2) begin
            chk("spacing_1", rise_cyc[1] - hs_cyc[0], 6);
            chk("spacing_2", rise_cyc[2] - hs_cyc[1], 6);
        end
        chk("spacing_done_once", done_cnt - d0, 1);

        // backpressure
        out_ready = 1'b0;
        got.delete();
        str = full_s;
        complete = 1'b1;
        tick();
        complete = 1'b0;
        for (int k = 0; k < 5 && !out_valid; k++) tick();
        chk("bp_valid_up", int'(out_valid), 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!out_valid || out_char != 7'b1111011) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        chk("bp_no_transfer", got.size(), 0);
        out_ready = 1'b1;
        tick();
        chk("bp_one_transfer", got.size(), 1);
        chk("bp_valid_drop", int'(out_valid), 0);
        wait_done(lat);
        tick();
        chk("bp_total", got.size(), 3 + EOL_N);

        // overrun: second complete three cycles after the first
        got.delete();
        o0 = ovr_cnt;
        str = full_s;
        complete = 1'b1;
        tick();
        complete = 1'b0;
        tick(); tick();
        str = {NCH{7'b0001000}};
        complete = 1'b1;
        tick();
        complete = 1'b0;
        wait_done(lat);
        tick();
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_count", got.size(), 3 + EOL_N);
        chk("ovr_char0", got.size() > 0 ? int'(got[0]) : -1, 7'b1111011);
        chk("ovr_char1", got.size() > 1 ? int'(got[1]) : -1, 7'b0000111);
        chk("ovr_char2", got.size() > 2 ? int'(got[2]) : -1, 7'b0111011);

        // reset in the middle of SEND
        out_ready = 1'b0;
        str = full_s;
        complete = 1'b1;
        tick();
        complete = 1'b0;
        for (int k = 0; k < 5 && !out_valid; k++) tick();
        d0 = done_cnt;
        #2 btn1 = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_char", int'(out_char), 0);
        chk("midrst_busy", int'(busy), 0);
        tick();
        btn1 = 1'b1;
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("midrst_idle_busy", int'(busy), 0);
        chk("midrst_idle_valid", int'(out_valid), 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
